// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller, one result bit per clock
//
// Time-shares a single 1-bit full adder to add two WIDTH-bit operands LSB first.
// Build option: SERIAL_ADD_SUB_EN adds the `sub` input (A - B via ~B + 1).
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      operation request, sampled only while idle
//   op_a   in   WIDTH  operand A, captured on acceptance
//   op_b   in   WIDTH  operand B, captured on acceptance
//   cin    in   1      carry-in, captured on acceptance
//   sub    in   1      (SERIAL_ADD_SUB_EN only) subtract, captured on acceptance
//   busy   out  1      high while running and in the done cycle
//   done   out  1      one-cycle pulse, result valid
//   sum    out  WIDTH  result, held until the next result
//   cout   out  1      final carry-out, held with sum

module serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    // Holds the upper WIDTH-1 bits of the result shift register; bit 0 of the
    // conceptual register is never needed because the last bit lands in sum directly.
    logic [WIDTH-2:0] r_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-2:0] r_d;
    logic [WIDTH-1:0] b_load_d;
    logic             c_load_d;

    always_comb begin
        fa_sum  = a_q[0] ^ b_q[0] ^ c_q;
        fa_cout = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        // New bit enters at the top; on the final bit this is the complete result.
        res_d   = {fa_sum, r_q};
        r_d     = res_d[WIDTH-1:1];
`ifdef SERIAL_ADD_SUB_EN
        // Two's complement subtract: A + ~B + 1; cout=1 then means no borrow.
        b_load_d = sub ? ~op_b : op_b;
        c_load_d = sub ? 1'b1 : cin;
`else
        b_load_d = op_b;
        c_load_d = cin;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= b_load_d;
                        c_q     <= c_load_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_q   <= r_d;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= fa_cout;
                    if (cnt_q == LAST_BIT) begin
                        // Result registers update only here, so no partial sum is visible.
                        sum_q   <= res_d;
                        cout_q  <= fa_cout;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    logic        sub = 1'b0;
`endif
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;

    int checks = 0;
    int failures = 0;
    logic [15:0] held_sum = '0;
    int done_at [$];

    serial_add_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one op and follows it to the done pulse; expects done exactly 16 edges after acceptance.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [15:0] exp_sum, input logic exp_cout);
        int k;
        op_a = a; op_b = b; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        op_a = 16'hDEAD; op_b = 16'hBEEF; cin = ~c;
        chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 8) chk({tag, "_no_partial"}, {16'd0, sum}, {16'd0, held_sum});
            if (done) begin
                k = i;
                break;
            end
        end
        chk({tag, "_latency"}, k, 32'd16);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
        chk({tag, "_sum"}, {16'd0, sum}, {16'd0, exp_sum});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
        held_sum = exp_sum;
        tick();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_sum_hold"}, {16'd0, sum}, {16'd0, exp_sum});
    endtask

    initial begin
        int seen;
        // Reset state
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, busy}, 32'd0);

        run_op("add3_5", 16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0);
        run_op("carry", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op("cin1", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);

        // Start pulses during RUN and during DONE must be ignored.
        op_a = 16'h0100; op_b = 16'h0200; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                op_a = 16'h00FF; op_b = 16'h0001; start = 1'b1;
            end
            tick();
            if (i == 5) start = 1'b0;
            if (done) begin
                seen++;
                chk("busy_ign_sum", {16'd0, sum}, 32'h0300);
                chk("busy_ign_cout", {31'd0, cout}, 32'd0);
                start = 1'b1;
                tick();
                start = 1'b0;
                break;
            end
        end
        for (int i = 0; i < 24; i++) begin
            if (done) seen++;
            tick();
        end
        chk("busy_ign_one_done", seen, 32'd1);
        chk("busy_ign_idle", {31'd0, busy}, 32'd0);
        chk("busy_ign_hold", {16'd0, sum}, 32'h0300);
        held_sum = 16'h0300;

        // Asynchronous reset in the middle of an operation (after bit 7 is processed).
        op_a = 16'h0F0F; op_b = 16'h0101; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_sum", {16'd0, sum}, 32'd0);
        chk("midrst_cout", {31'd0, cout}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_idle", {31'd0, busy}, 32'd0);
        held_sum = 16'h0000;
        run_op("after_rst", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        run_op("sub5_7", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
        run_op("sub7_5", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1);
        sub = 1'b0;
        run_op("sub0_add", 16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0);
`endif

        // Back-to-back with start held high: done every 18 cycles.
        op_a = 16'h8001; op_b = 16'h8002; cin = 1'b1; start = 1'b1;
        tick();
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (done) begin
                done_at.push_back(i);
                chk("b2b_sum", {16'd0, sum}, 32'h0004);
                chk("b2b_cout", {31'd0, cout}, 32'd1);
                if (done_at.size() == 3) break;
            end
        end
        start = 1'b0;
        chk("b2b_count", done_at.size(), 32'd3);
        if (done_at.size() == 3) begin
            chk("b2b_first", done_at[0], 32'd16);
            chk("b2b_gap1", done_at[1] - done_at[0], 32'd18);
            chk("b2b_gap2", done_at[2] - done_at[1], 32'd18);
        end
        tick(); tick();
        chk("b2b_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
